mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the CPU's single AXI4-Lite master port between two internal requesters: the instruction fetch unit (read-only) and the load/store unit (read or write). Sits between the pipeline and the `cpu` AXI4-Lite pins, converts a simple req/ack protocol into AXI4-Lite transactions, and allows exactly one outstanding transaction at a time.

## Interface
- No parameters; address/data width fixed at 32, strobe at 4.
- `clk` in 1: sole clock, rising edge.
- `rst_l` in 1: asynchronous, active-low reset.
- `if_req` in 1, `if_addr` in 32: fetch request and word address.
- `if_ack` out 1, `if_rdata` out 32, `if_err` out 1: fetch completion pulse, data, error.
- `ls_req` in 1, `ls_we` in 1, `ls_addr` in 32, `ls_wdata` in 32, `ls_wstrb` in 4: load/store request.
- `ls_ack` out 1, `ls_rdata` out 32, `ls_err` out 1: load/store completion pulse, load data, error.
- All AXI4-Lite master signals (`axi_aw*`, `axi_w*`, `axi_b*`, `axi_ar*`, `axi_r*`), same names and widths as the `cpu` ports.

## Operation
- Requester holds `*_req` and all request fields stable from assertion until the cycle its `*_ack` is high.
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE: if any request, grant one (see Configuration), latch address/data/strobe/direction/owner. Read → RADDR, write → WADDR.
- RADDR: `axi_arvalid`=1 until `axi_arready`; then RDATA.
- RDATA: `axi_rready`=1; on `axi_rvalid` latch `axi_rdata` and `axi_rresp` → DONE.
- WADDR: `axi_awvalid` and `axi_wvalid` raised together; each drops independently after its own handshake; when both done (same or different cycles) → WRESP.
- WRESP: `axi_bready`=1; on `axi_bvalid` latch `axi_bresp` → DONE.
- DONE: owner's `*_ack`=1 for exactly one cycle with `*_rdata` and `*_err`; → IDLE. No grant is made in DONE, so a requester dropping `req` after ack is never double-served.
- `*_err` = `resp[1]` (SLVERR/DECERR); OKAY and EXOKAY are not errors.
- `axi_arprot` = 3'b100 for fetch, 3'b000 for load; `axi_awprot` = 3'b000.
- `if_rdata`/`ls_rdata` hold last captured value; only valid while the ack is high.
- Writes return `ls_rdata` unchanged.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Reset values: every valid/ready/ack/err = 0, all address/data/rdata = 0, strobe = 0, prot = 0, state IDLE, round-robin pointer favours LSU.
- Minimum latency, zero-wait slave: request seen in cycle 0 → AR/AW valid in cycle 1 → R/B handshake cycle 2 → ack cycle 3. Back-to-back throughput: one transaction per 4 cycles.
- Slave stalls extend RADDR/RDATA/WADDR/WRESP indefinitely; no timeout.
- Simultaneous `if_req` and `ls_req` in IDLE resolved in the same cycle; loser waits, request stays pending.
- `rst_l` low mid-transaction: immediate abandonment, all outputs to reset values; no ack delivered.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; after a grant, the other requester has priority on the next simultaneous request.
- Not defined: fixed priority, LSU always wins over fetch; no pointer register.

## Structure
- `cpu_pkg`: `axi_resp_t` enum (OKAY, EXOKAY, SLVERR, DECERR), `mem_arb_state_t` enum, constants `AXI_PROT_INSTR` = 3'b100, `AXI_PROT_DATA` = 3'b000.
- Sub-module `mem_arb_grant`: two requests in, one-hot grant out, contains the round-robin pointer under `MEM_ARB_RR_EN`.

## Test plan
- Fetch alone, `if_addr`=0x0000_0100, slave returns 0xDEAD_BEEF OKAY zero-wait → `axi_araddr`=0x100, `axi_arprot`=3'b100, `if_ack` cycle 3, `if_rdata`=0xDEAD_BEEF, `if_err`=0.
- Store `ls_addr`=0x8000_0004, `ls_wdata`=0x1234_5678, `ls_wstrb`=4'b0011; `axi_awready` 2 cycles after `axi_wready` → AW/W drop independently, `ls_ack` once, BRESP SLVERR → `ls_err`=1.
- Both requests held continuously, 4 transactions → fixed: 4 LSU grants, fetch starved; with `MEM_ARB_RR_EN`: LSU, fetch, LSU, fetch.
- Load with `axi_arready` low 5 cycles and `axi_rvalid` delayed 3 → `axi_arvalid` stays 1 for 6 cycles, single `ls_ack`, RRESP DECERR → `ls_err`=1.
- `rst_l` pulsed low during RDATA → all outputs 0 asynchronously; after release, state IDLE, new fetch completes normally.
- Requester drops `req` the cycle after ack → exactly one AXI transaction per request, no duplicate AR.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: AXI4-Lite response codes, memory-arbiter FSM states, protection encodings
// and the grant-vector bit positions shared by mem_arbiter and mem_arb_grant.
package cpu_pkg;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP,
        ST_DONE
    } mem_arb_state_t;

    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

    localparam int unsigned GNT_LS = 0;
    localparam int unsigned GNT_IF = 1;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input axi_resp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: one-hot grant between fetch and load/store requests.
// MEM_ARB_RR_EN enables a round-robin priority pointer; otherwise the LSU always wins.
module mem_arb_grant
    import cpu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_if_req,
    input  logic       i_ls_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
    logic r_prio_if;

    // After any grant, the requester that was not served gets priority next.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio_if <= 1'b0;
        end else if (i_take) begin
            r_prio_if <= o_gnt[GNT_LS];
        end
    end

    always_comb begin
        o_gnt = '0;
        if (i_if_req && (!i_ls_req || r_prio_if)) begin
            o_gnt[GNT_IF] = 1'b1;
        end else if (i_ls_req) begin
            o_gnt[GNT_LS] = 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n ^ i_take;

    always_comb begin
        o_gnt = '0;
        if (i_ls_req) begin
            o_gnt[GNT_LS] = 1'b1;
        end else if (i_if_req) begin
            o_gnt[GNT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-Lite master between instruction fetch and load/store,
// one outstanding transaction at a time. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    mem_arb_state_t r_state, w_nxt_state;

    logic        r_owner_if,  w_nxt_owner_if;
    logic        r_arvalid,   w_nxt_arvalid;
    logic [31:0] r_araddr,    w_nxt_araddr;
    logic [2:0]  r_arprot,    w_nxt_arprot;
    logic        r_rready,    w_nxt_rready;
    logic        r_awvalid,   w_nxt_awvalid;
    logic [31:0] r_awaddr,    w_nxt_awaddr;
    logic        r_wvalid,    w_nxt_wvalid;
    logic [31:0] r_wdata,     w_nxt_wdata;
    logic [3:0]  r_wstrb,     w_nxt_wstrb;
    logic        r_bready,    w_nxt_bready;
    logic        r_if_ack,    w_nxt_if_ack;
    logic [31:0] r_if_rdata,  w_nxt_if_rdata;
    logic        r_if_err,    w_nxt_if_err;
    logic        r_ls_ack,    w_nxt_ls_ack;
    logic [31:0] r_ls_rdata,  w_nxt_ls_rdata;
    logic        r_ls_err,    w_nxt_ls_err;

    logic [1:0]  w_gnt;
    logic        w_take;
    logic        w_aw_done;
    logic        w_w_done;

    mem_arb_grant u_grant (
        .i_clk    (clk),
        .i_rst_n  (rst_l),
        .i_if_req (if_req),
        .i_ls_req (ls_req),
        .i_take   (w_take),
        .o_gnt    (w_gnt)
    );

    assign w_take    = (r_state == ST_IDLE) && (w_gnt != '0);
    assign w_aw_done = !r_awvalid || axi_awready;
    assign w_w_done  = !r_wvalid  || axi_wready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_owner_if = r_owner_if;
        w_nxt_arvalid  = r_arvalid;
        w_nxt_araddr   = r_araddr;
        w_nxt_arprot   = r_arprot;
        w_nxt_rready   = r_rready;
        w_nxt_awvalid  = r_awvalid;
        w_nxt_awaddr   = r_awaddr;
        w_nxt_wvalid   = r_wvalid;
        w_nxt_wdata    = r_wdata;
        w_nxt_wstrb    = r_wstrb;
        w_nxt_bready   = r_bready;
        w_nxt_if_ack   = 1'b0;
        w_nxt_if_rdata = r_if_rdata;
        w_nxt_if_err   = 1'b0;
        w_nxt_ls_ack   = 1'b0;
        w_nxt_ls_rdata = r_ls_rdata;
        w_nxt_ls_err   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt[GNT_LS]) begin
                    w_nxt_owner_if = 1'b0;
                    if (ls_we) begin
                        w_nxt_awvalid = 1'b1;
                        w_nxt_wvalid  = 1'b1;
                        w_nxt_awaddr  = ls_addr;
                        w_nxt_wdata   = ls_wdata;
                        w_nxt_wstrb   = ls_wstrb;
                        w_nxt_state   = ST_WADDR;
                    end else begin
                        w_nxt_arvalid = 1'b1;
                        w_nxt_araddr  = ls_addr;
                        w_nxt_arprot  = AXI_PROT_DATA;
                        w_nxt_state   = ST_RADDR;
                    end
                end else if (w_gnt[GNT_IF]) begin
                    w_nxt_owner_if = 1'b1;
                    w_nxt_arvalid  = 1'b1;
                    w_nxt_araddr   = if_addr;
                    w_nxt_arprot   = AXI_PROT_INSTR;
                    w_nxt_state    = ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (axi_arready) begin
                    w_nxt_arvalid = 1'b0;
                    w_nxt_rready  = 1'b1;
                    w_nxt_state   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (axi_rvalid) begin
                    w_nxt_rready = 1'b0;
                    w_nxt_state  = ST_DONE;
                    if (r_owner_if) begin
                        w_nxt_if_ack   = 1'b1;
                        w_nxt_if_rdata = axi_rdata;
                        w_nxt_if_err   = resp_is_err(axi_resp_t'(axi_rresp));
                    end else begin
                        w_nxt_ls_ack   = 1'b1;
                        w_nxt_ls_rdata = axi_rdata;
                        w_nxt_ls_err   = resp_is_err(axi_resp_t'(axi_rresp));
                    end
                end
            end
            // AW and W retire independently; leave once both have handshaken.
            ST_WADDR: begin
                if (r_awvalid && axi_awready) begin
                    w_nxt_awvalid = 1'b0;
                end
                if (r_wvalid && axi_wready) begin
                    w_nxt_wvalid = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_nxt_bready = 1'b1;
                    w_nxt_state  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (axi_bvalid) begin
                    w_nxt_bready = 1'b0;
                    w_nxt_ls_ack = 1'b1;
                    w_nxt_ls_err = resp_is_err(axi_resp_t'(axi_bresp));
                    w_nxt_state  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_owner_if <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arprot   <= '0;
            r_rready   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bready   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_if_err   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_ls_rdata <= '0;
            r_ls_err   <= 1'b0;
        end else begin
            r_owner_if <= w_nxt_owner_if;
            r_arvalid  <= w_nxt_arvalid;
            r_araddr   <= w_nxt_araddr;
            r_arprot   <= w_nxt_arprot;
            r_rready   <= w_nxt_rready;
            r_awvalid  <= w_nxt_awvalid;
            r_awaddr   <= w_nxt_awaddr;
            r_wvalid   <= w_nxt_wvalid;
            r_wdata    <= w_nxt_wdata;
            r_wstrb    <= w_nxt_wstrb;
            r_bready   <= w_nxt_bready;
            r_if_ack   <= w_nxt_if_ack;
            r_if_rdata <= w_nxt_if_rdata;
            r_if_err   <= w_nxt_if_err;
            r_ls_ack   <= w_nxt_ls_ack;
            r_ls_rdata <= w_nxt_ls_rdata;
            r_ls_err   <= w_nxt_ls_err;
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign if_err      = r_if_err;
    assign ls_ack      = r_ls_ack;
    assign ls_rdata    = r_ls_rdata;
    assign ls_err      = r_ls_err;
    assign axi_awaddr  = r_awaddr;
    assign axi_awprot  = AXI_PROT_DATA;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_wvalid  = r_wvalid;
    assign axi_bready  = r_bready;
    assign axi_araddr  = r_araddr;
    assign axi_arprot  = r_arprot;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = r_rready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
// and a delay-configurable AXI4-Lite slave. Honours MEM_ARB_RR_EN like the design.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        if_req, if_ack, if_err, ls_req, ls_we, ls_ack, ls_err;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    mem_arbiter u_dut (
        .clk(clk), .rst_l(rst_l),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Slave configuration and handshake log
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int          c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0;
    logic [31:0] sl_rdata = '0;
    logic [1:0]  sl_rresp = '0, sl_bresp = '0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] lg_araddr = '0, lg_awaddr = '0, lg_wdata = '0;
    logic [2:0]  lg_arprot = '0, lg_awprot = '0;
    logic [3:0]  lg_wstrb = '0;

    // Reference model state
    bit          m_favour_if = 1'b0;
    logic [31:0] m_ls_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_winner_if(input bit rq_if, input bit rq_ls);
        bit w;
        if (!rq_ls)      w = 1'b1;
        else if (!rq_if) w = 1'b0;
        else begin
`ifdef MEM_ARB_RR_EN
            w = m_favour_if;
`else
            w = 1'b0;
`endif
        end
        m_favour_if = !w;
        return w;
    endfunction

    function automatic int model_latency(input bit we);
        if (we) return 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        return 3 + ar_dly + r_dly;
    endfunction

    function automatic logic model_err(input logic [1:0] resp);
        return (resp == 2'd2) || (resp == 2'd3);
    endfunction

    // AXI4-Lite slave: each ready/valid rises after its configured number of wait cycles.
    initial begin
        {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid} = '0;
        axi_bresp = '0; axi_rdata = '0; axi_rresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid} = '0;
                c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
            end else begin
                if (axi_arvalid) begin
                    if (c_ar >= ar_dly) begin
                        axi_arready = 1'b1; c_ar = 0; ar_hs++;
                        lg_araddr = axi_araddr; lg_arprot = axi_arprot;
                    end else begin axi_arready = 1'b0; c_ar++; end
                end else begin axi_arready = 1'b0; c_ar = 0; end
                if (axi_rready) begin
                    if (c_r >= r_dly) begin
                        axi_rvalid = 1'b1; axi_rdata = sl_rdata; axi_rresp = sl_rresp; c_r = 0;
                    end else begin axi_rvalid = 1'b0; c_r++; end
                end else begin axi_rvalid = 1'b0; c_r = 0; end
                if (axi_awvalid) begin
                    if (c_aw >= aw_dly) begin
                        axi_awready = 1'b1; c_aw = 0; aw_hs++;
                        lg_awaddr = axi_awaddr; lg_awprot = axi_awprot;
                    end else begin axi_awready = 1'b0; c_aw++; end
                end else begin axi_awready = 1'b0; c_aw = 0; end
                if (axi_wvalid) begin
                    if (c_w >= w_dly) begin
                        axi_wready = 1'b1; c_w = 0; w_hs++;
                        lg_wdata = axi_wdata; lg_wstrb = axi_wstrb;
                    end else begin axi_wready = 1'b0; c_w++; end
                end else begin axi_wready = 1'b0; c_w = 0; end
                if (axi_bready) begin
                    if (c_b >= b_dly) begin
                        axi_bvalid = 1'b1; axi_bresp = sl_bresp; c_b = 0;
                    end else begin axi_bvalid = 1'b0; c_b++; end
                end else begin axi_bvalid = 1'b0; c_b = 0; end
            end
        end
    end

    task automatic run_txn(input bit is_if, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input bit drop_late,
                           output int lat, output int acks_if, output int acks_ls, output int arv_cyc,
                           output bit split, output logic [31:0] rdata, output logic err);
        int tail;
        bit pend;
        lat = -1; acks_if = 0; acks_ls = 0; arv_cyc = 0; split = 1'b0;
        rdata = 'x; err = 1'bx; tail = -1; pend = 1'b0;
        if (is_if) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wstrb = strb; ls_req = 1'b1;
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (pend) begin
                @(posedge clk); #1;
                if_req = 1'b0; ls_req = 1'b0; pend = 1'b0;
            end
            @(negedge clk);
            if (axi_arvalid) arv_cyc++;
            if (axi_awvalid != axi_wvalid) split = 1'b1;
            if (if_ack) begin
                acks_if++;
                if (lat < 0) begin rdata = if_rdata; err = if_err; end
            end
            if (ls_ack) begin
                acks_ls++;
                if (lat < 0) begin rdata = ls_rdata; err = ls_err; end
            end
            if ((if_ack || ls_ack) && lat < 0) begin
                lat = cyc;
                tail = cyc + 4;
                if (drop_late) pend = 1'b1;
                else begin if_req = 1'b0; ls_req = 1'b0; end
            end
            if (tail == cyc) break;
        end
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a_if, a_ls, arv, base_ar, base_aw, base_w, n_ack;
        bit sp, win;
        logic [31:0] rd, addr, wd, exp_rd;
        logic er;
        logic [3:0] st;
        bit who[8];
        int when[8];

        rst_l = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        #1;
        chk("rst_ctrl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, '0);
        chk("rst_ack_err", {if_ack, if_err, ls_ack, ls_err}, '0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_ls_rdata", ls_rdata, '0);
        chk("rst_araddr", axi_araddr, '0);
        chk("rst_prot_strb", {axi_arprot, axi_awprot, axi_wstrb}, '0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait fetch
        sl_rdata = 32'hDEAD_BEEF; sl_rresp = 2'd0; base_ar = ar_hs;
        win = model_winner_if(1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0100, '0, '0, 1'b0, lat, a_if, a_ls, arv, sp, rd, er);
        chk("fetch_lat", lat, 3);
        chk("fetch_ack_if", a_if, 1);
        chk("fetch_ack_ls", a_ls, 0);
        chk("fetch_rdata", rd, 32'hDEAD_BEEF);
        chk("fetch_err", er, 1'b0);
        chk("fetch_ar_count", ar_hs - base_ar, 1);
        chk("fetch_araddr", lg_araddr, 32'h0000_0100);
        chk("fetch_arprot", lg_arprot, 3'b100);
        chk("fetch_arvalid_cycles", arv, 1);

        // Store, AW ready two cycles after W ready, SLVERR response
        aw_dly = 2; w_dly = 0; b_dly = 0; sl_bresp = 2'd2;
        base_ar = ar_hs; base_aw = aw_hs; base_w = w_hs;
        win = model_winner_if(1'b0, 1'b1);
        run_txn(1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 1'b0, lat, a_if, a_ls, arv, sp, rd, er);
        chk("store_lat", lat, model_latency(1'b1));
        chk("store_split_valid", sp, 1'b1);
        chk("store_ack_ls", a_ls, 1);
        chk("store_ack_if", a_if, 0);
        chk("store_err", er, 1'b1);
        chk("store_aw_w_count", {16'(aw_hs - base_aw), 16'(w_hs - base_w)}, {16'd1, 16'd1});
        chk("store_ar_count", ar_hs - base_ar, 0);
        chk("store_awaddr", lg_awaddr, 32'h8000_0004);
        chk("store_wdata", lg_wdata, 32'h1234_5678);
        chk("store_wstrb_awprot", {lg_wstrb, lg_awprot}, {4'b0011, 3'b000});
        chk("store_ls_rdata_kept", rd, m_ls_rdata);

        // Load with AR and R stalls, DECERR
        aw_dly = 0; ar_dly = 5; r_dly = 3; sl_rdata = $urandom; sl_rresp = 2'd3;
        addr = $urandom; base_ar = ar_hs;
        win = model_winner_if(1'b0, 1'b1);
        run_txn(1'b0, 1'b0, addr, '0, '0, 1'b0, lat, a_if, a_ls, arv, sp, rd, er);
        m_ls_rdata = sl_rdata;
        chk("load_arvalid_cycles", arv, 6);
        chk("load_lat", lat, model_latency(1'b0));
        chk("load_ack_ls", a_ls, 1);
        chk("load_err", er, 1'b1);
        chk("load_rdata", rd, m_ls_rdata);
        chk("load_araddr", lg_araddr, addr);
        chk("load_arprot", lg_arprot, 3'b000);
        chk("load_ar_count", ar_hs - base_ar, 1);

        // Reset while waiting in RDATA
        ar_dly = 0; r_dly = 20; sl_rresp = 2'd0;
        win = model_winner_if(1'b1, 1'b0);
        if_addr = 32'h0000_0200; if_req = 1'b1;
        for (int i = 0; i < 20 && !axi_rready; i++) @(negedge clk);
        chk("rst_mid_reached_rdata", axi_rready, 1'b1);
        #2 rst_l = 1'b0;
        #1;
        chk("rst_mid_ctrl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, '0);
        chk("rst_mid_ack_err", {if_ack, if_err, ls_ack, ls_err}, '0);
        chk("rst_mid_if_rdata", if_rdata, '0);
        chk("rst_mid_ls_rdata", ls_rdata, '0);
        chk("rst_mid_araddr", axi_araddr, '0);
        m_favour_if = 1'b0; m_ls_rdata = '0;
        if_req = 1'b0; r_dly = 0;
        @(negedge clk);
        rst_l = 1'b1;
        n_ack = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_ack || ls_ack) n_ack++;
        end
        chk("rst_mid_no_ack", n_ack, 0);
        sl_rdata = $urandom;
        win = model_winner_if(1'b1, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0300, '0, '0, 1'b0, lat, a_if, a_ls, arv, sp, rd, er);
        chk("post_rst_fetch_lat", lat, 3);
        chk("post_rst_fetch_rdata", rd, sl_rdata);

        // Requests dropped the cycle after ack: exactly one AR each
        for (int k = 0; k < 2; k++) begin
            base_ar = ar_hs; sl_rdata = $urandom;
            win = model_winner_if(k == 0, k != 0);
            run_txn(k == 0, 1'b0, $urandom, '0, '0, 1'b1, lat, a_if, a_ls, arv, sp, rd, er);
            if (k != 0) m_ls_rdata = sl_rdata;
            repeat (4) @(negedge clk);
            chk($sformatf("late_drop%0d_ar_count", k), ar_hs - base_ar, 1);
            chk($sformatf("late_drop%0d_acks", k), a_if + a_ls, 1);
        end

        // Randomized single-requester transactions
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            sl_rdata = $urandom; sl_rresp = 2'($urandom_range(0, 3)); sl_bresp = 2'($urandom_range(0, 3));
            addr = $urandom; wd = $urandom; st = 4'($urandom);
            base_ar = ar_hs; base_aw = aw_hs;
            win = model_winner_if(kind == 0, kind != 0);
            run_txn(kind == 0, kind == 2, addr, wd, st, 1'b0, lat, a_if, a_ls, arv, sp, rd, er);
            chk($sformatf("rnd%0d_lat", i), lat, model_latency(kind == 2));
            chk($sformatf("rnd%0d_acks", i), {16'(a_if), 16'(a_ls)}, (kind == 0) ? {16'd1, 16'd0} : {16'd0, 16'd1});
            if (kind == 2) begin
                chk($sformatf("rnd%0d_err", i), er, model_err(sl_bresp));
                chk($sformatf("rnd%0d_rdata_kept", i), rd, m_ls_rdata);
                chk($sformatf("rnd%0d_aw", i), lg_awaddr, addr);
                chk($sformatf("rnd%0d_w", i), {lg_wdata[27:0], lg_wstrb}, {wd[27:0], st});
                chk($sformatf("rnd%0d_counts", i), {16'(ar_hs - base_ar), 16'(aw_hs - base_aw)}, {16'd0, 16'd1});
            end else begin
                exp_rd = sl_rdata;
                if (kind == 1) m_ls_rdata = sl_rdata;
                chk($sformatf("rnd%0d_err", i), er, model_err(sl_rresp));
                chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
                chk($sformatf("rnd%0d_ar", i), {lg_araddr[28:0], lg_arprot}, {addr[28:0], (kind == 0) ? 3'b100 : 3'b000});
                chk($sformatf("rnd%0d_counts", i), {16'(ar_hs - base_ar), 16'(aw_hs - base_aw)}, {16'd1, 16'd0});
            end
        end

        // Both requesters held for four transactions
        ar_dly = 0; r_dly = 0; sl_rresp = 2'd0; sl_rdata = $urandom;
        if_addr = 32'h0000_0400; ls_addr = 32'h0000_0800; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        n_ack = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (if_ack || ls_ack) begin
                if (n_ack < 8) begin who[n_ack] = if_ack; when[n_ack] = cyc; end
                n_ack++;
                if (n_ack == 4) begin if_req = 1'b0; ls_req = 1'b0; end
            end
        end
        chk("contest_ack_total", n_ack, 4);
        for (int k = 0; k < 4; k++) begin
            win = model_winner_if(1'b1, 1'b1);
            chk($sformatf("contest%0d_winner_if", k), who[k], win);
            chk($sformatf("contest%0d_ack_cycle", k), when[k], 3 + 4 * k);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
